// File: rtl/adc_sched_pkg.sv
// Shared types and helpers for the ADC/filter round-robin scheduler.
// Channel search works on a fixed-width mask so one function serves any NUM_CH <= MAX_CH.
package adc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        WAIT,
        PUSH,
        DONE
    } sched_state_t;

    localparam int OVERRUN_W = 8;
    localparam int MAX_CH    = 32;
    localparam int MAX_CH_W  = 5;

    typedef struct packed {
        logic                found;
        logic [MAX_CH_W-1:0] ch;
    } next_ch_t;

    // Lowest enabled channel strictly above cur; found=0 when none remain.
    function automatic next_ch_t next_enabled(input logic [MAX_CH-1:0] mask,
                                              input logic [MAX_CH_W-1:0] cur);
        next_ch_t r;
        r = '0;
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r.found = 1'b1;
                r.ch    = MAX_CH_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_filter_scheduler_if.sv
// ADC-side and filter-side signals of the scheduler, bundled for port connection.
// master = scheduler, slave = ADC front end plus filter bank.
interface adc_filter_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 10
);
    import adc_sched_pkg::*;

    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]    ChEnable;
    logic                 AdcStart;
    logic [CH_W-1:0]      AdcCh;
    logic                 AdcDone;
    logic [DATA_W-1:0]    AdcData;
    logic                 FiltValid;
    logic                 FiltReady;
    logic [CH_W-1:0]      FiltCh;
    logic [DATA_W-1:0]    FiltData;
    logic                 SweepDone;
    logic [OVERRUN_W-1:0] OverrunCnt;
    logic                 TimeoutErr;

    modport master (
        input  ChEnable, AdcDone, AdcData, FiltReady,
        output AdcStart, AdcCh, FiltValid, FiltCh, FiltData, SweepDone, OverrunCnt, TimeoutErr
    );

    modport slave (
        output ChEnable, AdcDone, AdcData, FiltReady,
        input  AdcStart, AdcCh, FiltValid, FiltCh, FiltData, SweepDone, OverrunCnt, TimeoutErr
    );

endinterface

// File: rtl/adc_sample_tick.sv
// Sweep-period divider: counts 0..TICK_DIV-1 and raises tick on the wrap cycle.
module adc_sample_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_W'(TICK_DIV - 1));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || tick) cnt <= '0;
        else             cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/adc_filter_scheduler.sv
// Round-robin sweep over enabled ADC channels, handing each sample to the shared filter.
// Optional build macro ADC_TIMEOUT_EN adds a WAIT-state abort after TIMEOUT_CYC cycles.
module adc_filter_scheduler
    import adc_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 10,
    parameter int TICK_DIV    = 50000,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    adc_filter_scheduler_if.master bus
);
    localparam int CH_W = $clog2(NUM_CH);

    sched_state_t         state, state_nxt;
    logic                 tick;
    logic                 timeout;
    logic [NUM_CH-1:0]    mask_q;
    logic                 first_q;
    logic [CH_W-1:0]      ch_q;
    logic [CH_W-1:0]      fch_q;
    logic [DATA_W-1:0]    data_q;
    logic [OVERRUN_W-1:0] ovr_q;
    next_ch_t             nxt_after, nxt_first;
    logic [CH_W-1:0]      sel_ch;

    adc_sample_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

`ifdef ADC_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] wait_cnt;

    // Held at zero outside WAIT, so every WAIT entry starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + TO_W'(1);
    end

    assign timeout = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    // The first step of a sweep has no previously serviced channel, so channel 0 is eligible.
    always_comb begin
        nxt_after = next_enabled(MAX_CH'(mask_q), MAX_CH_W'(ch_q));
        nxt_first = next_enabled(MAX_CH'(mask_q), '0);
        if (!first_q)                         sel_ch = CH_W'(nxt_after.ch);
        else if (mask_q[0] || !nxt_first.found) sel_ch = '0;
        else                                  sel_ch = CH_W'(nxt_first.ch);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (tick && (|bus.ChEnable)) state_nxt = SELECT;
            SELECT: state_nxt = START;
            START:  state_nxt = WAIT;
            WAIT: begin
                if (timeout)          state_nxt = nxt_after.found ? SELECT : DONE;
                else if (bus.AdcDone) state_nxt = PUSH;
            end
            PUSH:   if (bus.FiltReady) state_nxt = nxt_after.found ? SELECT : DONE;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.AdcStart   = (state == START);
        bus.FiltValid  = (state == PUSH);
        bus.SweepDone  = (state == DONE);
        bus.TimeoutErr = timeout;
        bus.AdcCh      = ch_q;
        bus.FiltCh     = fch_q;
        bus.FiltData   = data_q;
        bus.OverrunCnt = ovr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q  <= '0;
            first_q <= 1'b0;
            ch_q    <= '0;
            fch_q   <= '0;
            data_q  <= '0;
            ovr_q   <= '0;
        end else begin
            if (state == IDLE && tick && (|bus.ChEnable)) begin
                mask_q  <= bus.ChEnable;
                first_q <= 1'b1;
            end
            if (state == SELECT) begin
                ch_q    <= sel_ch;
                first_q <= 1'b0;
            end
            if (state == WAIT && bus.AdcDone && !timeout) begin
                data_q <= bus.AdcData;
                fch_q  <= ch_q;
            end
            if (tick && state != IDLE && ovr_q != '1) ovr_q <= ovr_q + OVERRUN_W'(1);
        end
    end

endmodule

// File: tb/tb_adc_filter_scheduler.sv
// Directed bench for adc_filter_scheduler: sweep-table vectors plus hand-written
// sequences for back-pressure, idle ticks, timeout/hang, reset in PUSH and overrun.
module tb_adc_filter_scheduler;
    localparam int NUM_CH   = 4;
    localparam int DATA_W   = 10;
    localparam int TICK_DIV = 64;
    localparam int TO_CYC   = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    adc_filter_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    adc_filter_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TICK_DIV(TICK_DIV), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ch;
        logic [9:0] d;
    } hs_t;

    typedef struct packed {
        logic [3:0]       en;
        logic [3:0]       mid_en;
        logic [2:0]       n;
        logic [3:0][1:0]  chs;
        logic [3:0][9:0]  dat;
    } vec_t;

    hs_t hs_q[$];
    int  sd_cnt = 0, as_cnt = 0, to_cnt = 0;
    int  adc_lat = 3;
    int  adc_mute_ch = -1;

    // ADC model: answers adc_lat cycles after AdcStart with ch*100; a muted channel never answers.
    int         a_cnt;
    bit         a_pend = 1'b0;
    logic [1:0] a_ch;
    always @(negedge clk) begin
        bus.AdcDone = 1'b0;
        bus.AdcData = 10'h3FF;
        if (rst) begin
            a_pend = 1'b0;
        end else begin
            if (a_pend) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    bus.AdcDone = 1'b1;
                    bus.AdcData = 10'(int'(a_ch) * 100);
                    a_pend      = 1'b0;
                end
            end
            if (bus.AdcStart && !a_pend && int'(bus.AdcCh) != adc_mute_ch) begin
                a_pend = 1'b1;
                a_cnt  = adc_lat;
                a_ch   = bus.AdcCh;
            end
        end
    end

    // Event recorder, sampled mid-cycle after the bench has driven its inputs.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (bus.FiltValid && bus.FiltReady) hs_q.push_back('{ch: bus.FiltCh, d: bus.FiltData});
            if (bus.SweepDone)  sd_cnt++;
            if (bus.AdcStart)   as_cnt++;
            if (bus.TimeoutErr) to_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int s0 = sd_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (sd_cnt != s0) ok = 1'b1;
        end
        step();
        step();
    endtask

    task automatic wait_high(input bit which_valid, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (which_valid ? bus.FiltValid : bus.AdcStart) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] mid, input int n,
                                input logic [1:0] c0, c1, c2, c3,
                                input logic [9:0] d0, d1, d2, d3);
        vec_t v;
        v.en = en; v.mid_en = mid; v.n = 3'(n);
        v.chs[0] = c0; v.chs[1] = c1; v.chs[2] = c2; v.chs[3] = c3;
        v.dat[0] = d0; v.dat[1] = d1; v.dat[2] = d2; v.dat[3] = d3;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        bit  ok;
        int  sd0, as0, to0, k, pulse_at;
        int  starts[$];
        logic [1:0] h_ch;
        logic [9:0] h_d;
        bit  stable;

        vecs[0] = mk(4'b1011, 4'b1011, 3, 0, 1, 3, 0,   0, 100, 300,   0);
        vecs[1] = mk(4'b1011, 4'b0100, 3, 0, 1, 3, 0,   0, 100, 300,   0);
        vecs[2] = mk(4'b1111, 4'b1111, 4, 0, 1, 2, 3,   0, 100, 200, 300);
        vecs[3] = mk(4'b1000, 4'b0001, 1, 3, 0, 0, 0, 300,   0,   0,   0);
        vecs[4] = mk(4'b0001, 4'b0001, 1, 0, 0, 0, 0,   0,   0,   0,   0);
        vecs[5] = mk(4'b0110, 4'b0110, 2, 1, 2, 0, 0, 100, 200,   0,   0);

        rst = 1'b1;
        bus.ChEnable  = '0;
        bus.FiltReady = 1'b0;
        step();
        step();
        check("rst_AdcStart",   bus.AdcStart,   0);
        check("rst_FiltValid",  bus.FiltValid,  0);
        check("rst_SweepDone",  bus.SweepDone,  0);
        check("rst_OverrunCnt", bus.OverrunCnt, 0);
        check("rst_FiltData",   bus.FiltData,   0);
        check("rst_TimeoutErr", bus.TimeoutErr, 0);
        rst = 1'b0;
        bus.FiltReady = 1'b1;

        // Sweep table: handoff order/data, one SweepDone, mid-sweep enable changes ignored.
        for (int v = 0; v < 6; v++) begin
            hs_q.delete();
            sd0 = sd_cnt;
            bus.ChEnable = vecs[v].en;
            wait_high(1'b0, 3 * TICK_DIV, ok);
            check($sformatf("v%0d_start_seen", v), ok, 1);
            bus.ChEnable = vecs[v].mid_en;
            wait_done(3 * TICK_DIV, ok);
            check($sformatf("v%0d_done_seen", v), ok, 1);
            check($sformatf("v%0d_hs_count", v), hs_q.size(), vecs[v].n);
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                if (i < hs_q.size()) begin
                    check($sformatf("v%0d_ch%0d", v, i),   hs_q[i].ch, vecs[v].chs[i]);
                    check($sformatf("v%0d_data%0d", v, i), hs_q[i].d,  vecs[v].dat[i]);
                end
            end
            check($sformatf("v%0d_sweepdone", v), sd_cnt - sd0, 1);
            check($sformatf("v%0d_overrun", v), bus.OverrunCnt, 0);
        end

        // Back-pressure: PUSH held 5 cycles, then AdcStart exactly 2 cycles after handshake.
        bus.FiltReady = 1'b0;
        bus.ChEnable  = 4'b0110;
        hs_q.delete();
        wait_high(1'b1, 3 * TICK_DIV, ok);
        check("bp_valid_seen", ok, 1);
        h_ch = bus.FiltCh;
        h_d  = bus.FiltData;
        check("bp_ch",   h_ch, 1);
        check("bp_data", h_d,  100);
        stable = 1'b1;
        repeat (5) begin
            step();
            if (bus.FiltValid !== 1'b1 || bus.FiltCh !== h_ch || bus.FiltData !== h_d) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        bus.FiltReady = 1'b1;
        step();
        check("bp_h1_AdcStart",  bus.AdcStart,  0);
        check("bp_h1_FiltValid", bus.FiltValid, 0);
        step();
        check("bp_h2_AdcStart", bus.AdcStart, 1);
        check("bp_h2_AdcCh",    bus.AdcCh,    2);
        wait_done(3 * TICK_DIV, ok);
        check("bp_done_seen", ok, 1);
        check("bp_hs_count", hs_q.size(), 2);

        // Zero enable at tick is ignored; later enable sweeps ch2 only.
        bus.ChEnable = 4'b0000;
        as0 = as_cnt;
        sd0 = sd_cnt;
        repeat (2 * TICK_DIV) step();
        check("zero_no_start",   as_cnt - as0, 0);
        check("zero_no_done",    sd_cnt - sd0, 0);
        check("zero_no_overrun", bus.OverrunCnt, 0);
        hs_q.delete();
        bus.ChEnable = 4'b0100;
        wait_done(3 * TICK_DIV, ok);
        check("ch2_done_seen", ok, 1);
        check("ch2_hs_count", hs_q.size(), 1);
        if (hs_q.size() > 0) check("ch2_data", hs_q[0].d, 200);
        check("ch2_starts", as_cnt - as0, 1);

        // Silent ch1: abort after TIMEOUT_CYC when enabled, otherwise hang in WAIT.
        bus.ChEnable = 4'b0000;
        repeat (2 * TICK_DIV) step();
        hs_q.delete();
        adc_mute_ch = 1;
        to0 = to_cnt;
        as0 = as_cnt;
        sd0 = sd_cnt;
        bus.ChEnable = 4'b0110;
        wait_high(1'b0, 3 * TICK_DIV, ok);
        check("to_start_seen", ok, 1);
        check("to_start_ch",   bus.AdcCh, 1);
`ifdef ADC_TIMEOUT_EN
        pulse_at = -1;
        for (int j = 1; j <= 9; j++) begin
            step();
            if (bus.TimeoutErr && pulse_at < 0) pulse_at = j;
        end
        check("to_pulse_cycle", pulse_at, TO_CYC + 1);
        wait_done(3 * TICK_DIV, ok);
        check("to_done_seen", ok, 1);
        check("to_pulses", to_cnt - to0, 1);
        check("to_hs_count", hs_q.size(), 1);
        if (hs_q.size() > 0) check("to_hs_ch2", hs_q[0].ch, 2);
`else
        pulse_at = 0;
        repeat (40) step();
        check("hang_no_timeout", to_cnt - to0, 0);
        check("hang_no_hs",      hs_q.size(), 0);
        check("hang_one_start",  as_cnt - as0, 1);
        check("hang_no_done",    sd_cnt - sd0, 0);
        check("hang_err_low",    bus.TimeoutErr, 0 + pulse_at);
`endif
        adc_mute_ch  = -1;
        bus.ChEnable = 4'b0000;
        do_reset();

        // Reset while FiltValid is high drops the sample; then check tick latency and period.
        bus.FiltReady = 1'b0;
        bus.ChEnable  = 4'b0100;
        wait_high(1'b1, 3 * TICK_DIV, ok);
        check("rp_valid_seen", ok, 1);
        hs_q.delete();
        rst = 1'b1;
        step();
        check("rp_AdcStart",   bus.AdcStart,   0);
        check("rp_AdcCh",      bus.AdcCh,      0);
        check("rp_FiltValid",  bus.FiltValid,  0);
        check("rp_FiltCh",     bus.FiltCh,     0);
        check("rp_FiltData",   bus.FiltData,   0);
        check("rp_SweepDone",  bus.SweepDone,  0);
        check("rp_OverrunCnt", bus.OverrunCnt, 0);
        rst = 1'b0;
        bus.FiltReady = 1'b1;
        k = 0;
        while (k < 140) begin
            step();
            k++;
            if (bus.AdcStart) starts.push_back(k);
            if (k == TICK_DIV + 1) check("rp_no_stale_hs", hs_q.size(), 0);
        end
        check("rp_start_count", starts.size(), 2);
        if (starts.size() == 2) begin
            check("rp_first_start",  starts[0], TICK_DIV + 1);
            check("rp_second_start", starts[1], 2 * TICK_DIV + 1);
        end
        check("rp_hs_count", hs_q.size(), 2);

`ifndef ADC_TIMEOUT_EN
        // Overrun: ch2 never answers; sweep started at tick c191, later ticks are dropped.
        adc_mute_ch = 2;
        while (k < 255)   begin step(); k++; end
        check("ovr_before_first", bus.OverrunCnt, 0);
        step(); k++;
        check("ovr_first", bus.OverrunCnt, 1);
        while (k < 320)   begin step(); k++; end
        check("ovr_second", bus.OverrunCnt, 2);
        while (k < 16511) begin step(); k++; end
        check("ovr_254", bus.OverrunCnt, 254);
        step(); k++;
        check("ovr_255", bus.OverrunCnt, 255);
        while (k < 19392) begin step(); k++; end
        check("ovr_saturated", bus.OverrunCnt, 255);
        adc_mute_ch  = -1;
        bus.ChEnable = 4'b0000;
        do_reset();
        step();
        check("ovr_after_reset", bus.OverrunCnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
